// File: rtl/ball_rx_pkg.sv
// Shared types and constants for the I2C ball receive loader.
//   state_t    : loader FSM states
//   ball_pkt_t : validated ball packet handed to game logic
//   SCREEN_H, BALL_SIZE, Y_MAX_DEF : screen geometry used for y clamping
package ball_rx_pkg;

  localparam int SCREEN_H  = 480;
  localparam int BALL_SIZE = 10;
  localparam int Y_MAX_DEF = SCREEN_H - BALL_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CHECK,
    WAIT_FRAME,
    SPAWN,
    DONE
  } state_t;

  typedef struct packed {
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] gravity;
    logic       collision;
  } ball_pkt_t;

endpackage

// File: rtl/ball_rx_validate.sv
// Combinational packet validation: assembles the 10-bit y position from the
// two received bytes, clamps it to Y_MAX and packs the remaining fields.
//   y_lo, y_hi     : received y[7:0] and y[9:8]
//   vy             : vertical velocity, passed through unchanged
//   gravity        : gravity counter
//   collision      : collision flag
//   pkt            : validated packet
//   clamped        : y exceeded Y_MAX and was clamped
module ball_rx_validate
  import ball_rx_pkg::*;
#(
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic [7:0] y_lo,
  input  logic [1:0] y_hi,
  input  logic [7:0] vy,
  input  logic [1:0] gravity,
  input  logic       collision,
  output ball_pkt_t  pkt,
  output logic       clamped
);

  logic [9:0] y_raw;

  always_comb begin
    y_raw         = {y_hi, y_lo};
    clamped       = (y_raw > 10'(Y_MAX));
    pkt.y         = clamped ? 10'(Y_MAX) : y_raw;
    pkt.vy        = vy;
    pkt.gravity   = gravity;
    pkt.collision = collision;
  end

endmodule

// File: rtl/i2c_ball_rx_loader.sv
// Receives a ball packet from the I2C slave registers, validates it and issues
// a single spawn request to local game logic aligned to a frame tick.
//   clk, reset        : clock and asynchronous active-low reset
//   i_y_pos0/1        : received y position bytes (y[9:8] in i_y_pos1[1:0])
//   i_y_vel           : received vertical velocity (two's complement)
//   i_gravity         : received gravity counter in bits [1:0]
//   i_is_collusion    : received collision flag in bit 0
//   go_left           : packet-complete level from the slave side
//   frame_tick        : start-of-frame pulse
//   ball_busy         : local ball already in play, spawn must wait
//   spawn_ready       : game logic accepts the spawn request
//   spawn_*           : spawn request and its packet fields
//   y_clamped         : last accepted packet had its y clamped
//   responsing_i2c    : busy indication back to the I2C interface
//   dbg_led           : {overrun_cnt, drop_cnt} when BALL_RX_DEBUG_CNT_EN is
//                       defined, otherwise 0
module i2c_ball_rx_loader
  import ball_rx_pkg::*;
#(
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_y_pos0,
  input  logic [7:0] i_y_pos1,
  input  logic [7:0] i_y_vel,
  input  logic [7:0] i_gravity,
  input  logic [7:0] i_is_collusion,
  input  logic       go_left,
  input  logic       frame_tick,
  input  logic       ball_busy,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [9:0] spawn_y,
  output logic [7:0] spawn_vy,
  output logic [1:0] spawn_gravity,
  output logic       spawn_collision,
  output logic       y_clamped,
  output logic       responsing_i2c,
  output logic [7:0] dbg_led
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t     state_q, state_d;
  logic       go_left_q;
  logic       go_rise;
  logic       pending_q;
  logic [TW-1:0] tmo_q;
  logic       tmo_hit;
  logic       drop_evt;
  logic       overrun_evt;

  logic [7:0] sh_y_lo;
  logic [1:0] sh_y_hi;
  logic [7:0] sh_vy;
  logic [1:0] sh_grav;
  logic       sh_coll;

  ball_pkt_t  val_pkt;
  logic       val_clamped;
  ball_pkt_t  out_pkt_q;
  logic       clamped_q;

  assign go_rise     = go_left & ~go_left_q;
  assign tmo_hit     = (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign drop_evt    = (state_q == SPAWN) && tmo_hit && !spawn_ready;
  // A rise in DONE while a packet is pending simply becomes the next pending
  // packet, because the current pending one is being serviced right now.
  assign overrun_evt = go_rise && pending_q && (state_q != IDLE) && (state_q != DONE);

  ball_rx_validate #(.Y_MAX(Y_MAX)) u_validate (
    .y_lo      (sh_y_lo),
    .y_hi      (sh_y_hi),
    .vy        (sh_vy),
    .gravity   (sh_grav),
    .collision (sh_coll),
    .pkt       (val_pkt),
    .clamped   (val_clamped)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (go_rise) state_d = CAPTURE;
      CAPTURE:    state_d = CHECK;
      CHECK:      state_d = WAIT_FRAME;
      WAIT_FRAME: if (frame_tick && !ball_busy) state_d = SPAWN;
      SPAWN:      if (spawn_ready || tmo_hit) state_d = DONE;
      DONE:       state_d = pending_q ? CAPTURE : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      go_left_q <= 1'b0;
      pending_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      go_left_q <= go_left;
      if (state_q == DONE && pending_q)
        pending_q <= go_rise;
      else if (go_rise && state_q != IDLE)
        pending_q <= 1'b1;
      // Held at zero outside SPAWN so it starts from zero on every entry.
      if (state_q == SPAWN)
        tmo_q <= tmo_q + 1'b1;
      else
        tmo_q <= '0;
    end
  end

  // Snapshot is taken in CAPTURE; the validated result is latched in CHECK
  // and held stable through WAIT_FRAME and SPAWN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_y_lo   <= '0;
      sh_y_hi   <= '0;
      sh_vy     <= '0;
      sh_grav   <= '0;
      sh_coll   <= 1'b0;
      out_pkt_q <= '0;
      clamped_q <= 1'b0;
    end else begin
      if (state_q == CAPTURE) begin
        sh_y_lo <= i_y_pos0;
        sh_y_hi <= i_y_pos1[1:0];
        sh_vy   <= i_y_vel;
        sh_grav <= i_gravity[1:0];
        sh_coll <= i_is_collusion[0];
      end
      if (state_q == CHECK) begin
        out_pkt_q <= val_pkt;
        clamped_q <= val_clamped;
      end
    end
  end

  // Decoded straight from the state register so reset removes the request
  // immediately rather than at the next edge.
  assign spawn_valid     = (state_q == SPAWN);
  assign responsing_i2c  = (state_q == CAPTURE) || (state_q == CHECK) ||
                           (state_q == WAIT_FRAME) || (state_q == SPAWN);
  assign spawn_y         = out_pkt_q.y;
  assign spawn_vy        = out_pkt_q.vy;
  assign spawn_gravity   = out_pkt_q.gravity;
  assign spawn_collision = out_pkt_q.collision;
  assign y_clamped       = clamped_q;

`ifdef BALL_RX_DEBUG_CNT_EN
  logic [CNT_W-1:0] overrun_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (overrun_evt && overrun_cnt_q != '1) overrun_cnt_q <= overrun_cnt_q + 1'b1;
      if (drop_evt && drop_cnt_q != '1)       drop_cnt_q    <= drop_cnt_q + 1'b1;
    end
  end

  assign dbg_led = {4'(overrun_cnt_q), 4'(drop_cnt_q)};

  logic unused_bits;
  assign unused_bits = ^{i_y_pos1[7:2], i_gravity[7:2], i_is_collusion[7:1]};
`else
  assign dbg_led = 8'h00;

  logic unused_bits;
  assign unused_bits = ^{i_y_pos1[7:2], i_gravity[7:2], i_is_collusion[7:1],
                         drop_evt, overrun_evt};
`endif

endmodule

// File: tb/tb_i2c_ball_rx_loader.sv
// Directed testbench for i2c_ball_rx_loader (TIMEOUT_CYC overridden to 16).
// dbg_led expectations follow whether BALL_RX_DEBUG_CNT_EN is defined.
module tb_i2c_ball_rx_loader;
  import ball_rx_pkg::*;

`ifdef BALL_RX_DEBUG_CNT_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] i_y_pos0 = '0, i_y_pos1 = '0, i_y_vel = '0, i_gravity = '0, i_is_collusion = '0;
  logic       go_left = 1'b0, frame_tick = 1'b0, ball_busy = 1'b0, spawn_ready = 1'b0;
  logic       spawn_valid;
  logic [9:0] spawn_y;
  logic [7:0] spawn_vy;
  logic [1:0] spawn_gravity;
  logic       spawn_collision, y_clamped, responsing_i2c;
  logic [7:0] dbg_led;

  int checks = 0;
  int failures = 0;

  i2c_ball_rx_loader #(.TIMEOUT_CYC(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_y_pos0        (i_y_pos0),
    .i_y_pos1        (i_y_pos1),
    .i_y_vel         (i_y_vel),
    .i_gravity       (i_gravity),
    .i_is_collusion  (i_is_collusion),
    .go_left         (go_left),
    .frame_tick      (frame_tick),
    .ball_busy       (ball_busy),
    .spawn_ready     (spawn_ready),
    .spawn_valid     (spawn_valid),
    .spawn_y         (spawn_y),
    .spawn_vy        (spawn_vy),
    .spawn_gravity   (spawn_gravity),
    .spawn_collision (spawn_collision),
    .y_clamped       (y_clamped),
    .responsing_i2c  (responsing_i2c),
    .dbg_led         (dbg_led)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Leaves the FSM in WAIT_FRAME with the packet latched.
  task automatic send_packet(input logic [7:0] y0, input logic [7:0] y1, input logic [7:0] vy,
                             input logic [7:0] g, input logic [7:0] c);
    i_y_pos0 = y0; i_y_pos1 = y1; i_y_vel = vy; i_gravity = g; i_is_collusion = c;
    go_left = 1'b0; step();
    go_left = 1'b1; step();
    go_left = 1'b0; step();
    step();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({spawn_valid, spawn_y, spawn_vy, spawn_gravity, spawn_collision, y_clamped, responsing_i2c, dbg_led} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b y=%0d vy=%0h g=%0d c=%0b clamp=%0b resp=%0b dbg=%0h expected all 0",
               spawn_valid, spawn_y, spawn_vy, spawn_gravity, spawn_collision, y_clamped, responsing_i2c, dbg_led);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    spawn_ready = 1'b1;
    i_y_pos0 = 8'h2C; i_y_pos1 = 8'h01; i_y_vel = 8'hF6; i_gravity = 8'h02; i_is_collusion = 8'h01;
    go_left = 1'b0; step();
    go_left = 1'b1; step();
    checks++;
    if (responsing_i2c !== 1'b1) begin
      failures++; $display("FAIL basic_resp_capture: got %0b expected 1", responsing_i2c);
    end
    repeat (19) step();
    checks++;
    if (spawn_valid !== 1'b0) begin
      failures++; $display("FAIL basic_no_early_valid: got %0b expected 0", spawn_valid);
    end
    tick();
    checks++;
    if (spawn_valid !== 1'b1 || spawn_y !== 10'd300 || spawn_vy !== 8'hF6 ||
        spawn_gravity !== 2'd2 || spawn_collision !== 1'b1 || y_clamped !== 1'b0) begin
      failures++;
      $display("FAIL basic_spawn: valid=%0b y=%0d vy=%0h g=%0d c=%0b clamp=%0b expected 1 300 f6 2 1 0",
               spawn_valid, spawn_y, spawn_vy, spawn_gravity, spawn_collision, y_clamped);
    end
    step();
    checks++;
    if (spawn_valid !== 1'b0 || responsing_i2c !== 1'b0) begin
      failures++; $display("FAIL basic_one_cycle: valid=%0b resp=%0b expected 0 0", spawn_valid, responsing_i2c);
    end
    step();
    go_left = 1'b0;
    step();
    checks++;
    if (responsing_i2c !== 1'b0 || spawn_valid !== 1'b0) begin
      failures++; $display("FAIL basic_idle: resp=%0b valid=%0b expected 0 0", responsing_i2c, spawn_valid);
    end
  endtask

  task automatic test_clamp();
    logic [7:0] y0s [4] = '{8'hFF, 8'hD6, 8'hD7, 8'h00};
    logic [7:0] y1s [4] = '{8'h03, 8'h01, 8'h01, 8'hFC};
    logic [9:0] exp_y [4] = '{10'd470, 10'd470, 10'd470, 10'd0};
    logic       exp_c [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    spawn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_packet(y0s[i], y1s[i], 8'h05, 8'h01, 8'h00);
      tick();
      checks++;
      if (spawn_valid !== 1'b1 || spawn_y !== exp_y[i] || y_clamped !== exp_c[i] ||
          spawn_gravity !== 2'd1 || spawn_collision !== 1'b0) begin
        failures++;
        $display("FAIL clamp_%0d: valid=%0b y=%0d clamp=%0b g=%0d c=%0b expected 1 %0d %0b 1 0",
                 i, spawn_valid, spawn_y, y_clamped, spawn_gravity, spawn_collision, exp_y[i], exp_c[i]);
      end
      step();
      step();
    end
  endtask

  task automatic test_busy();
    spawn_ready = 1'b1;
    send_packet(8'h40, 8'h00, 8'h03, 8'h00, 8'h00);
    ball_busy = 1'b1;
    tick();
    checks++;
    if (spawn_valid !== 1'b0) begin
      failures++; $display("FAIL busy_tick1: valid=%0b expected 0", spawn_valid);
    end
    repeat (3) step();
    tick();
    checks++;
    if (spawn_valid !== 1'b0 || responsing_i2c !== 1'b1) begin
      failures++; $display("FAIL busy_tick2: valid=%0b resp=%0b expected 0 1", spawn_valid, responsing_i2c);
    end
    ball_busy = 1'b0;
    repeat (2) step();
    checks++;
    if (spawn_valid !== 1'b0) begin
      failures++; $display("FAIL busy_no_tick: valid=%0b expected 0", spawn_valid);
    end
    tick();
    checks++;
    if (spawn_valid !== 1'b1 || spawn_y !== 10'd64) begin
      failures++; $display("FAIL busy_tick3: valid=%0b y=%0d expected 1 64", spawn_valid, spawn_y);
    end
    step();
    step();
  endtask

  task automatic test_timeout();
    int n;
    spawn_ready = 1'b0;
    send_packet(8'h10, 8'h00, 8'h01, 8'h00, 8'h00);
    tick();
    n = 0;
    for (int i = 0; i < 40 && spawn_valid === 1'b1; i++) begin
      n++;
      step();
    end
    checks++;
    if (n != 16 || spawn_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_len: valid cycles=%0d valid=%0b expected 16 0", n, spawn_valid);
    end
    step();
    checks++;
    if (responsing_i2c !== 1'b0 || dbg_led !== (DBG ? 8'h01 : 8'h00)) begin
      failures++; $display("FAIL timeout_idle: resp=%0b dbg=%0h expected 0 %0h", responsing_i2c, dbg_led, DBG ? 8'h01 : 8'h00);
    end
  endtask

  task automatic test_timeout_edge();
    spawn_ready = 1'b0;
    send_packet(8'h20, 8'h00, 8'h01, 8'h00, 8'h00);
    tick();
    repeat (15) step();
    checks++;
    if (spawn_valid !== 1'b1) begin
      failures++; $display("FAIL edge_still_valid: valid=%0b expected 1", spawn_valid);
    end
    spawn_ready = 1'b1;
    step();
    step();
    checks++;
    if (spawn_valid !== 1'b0 || responsing_i2c !== 1'b0 || dbg_led !== (DBG ? 8'h01 : 8'h00)) begin
      failures++; $display("FAIL edge_accept_wins: valid=%0b resp=%0b dbg=%0h expected 0 0 %0h",
                           spawn_valid, responsing_i2c, dbg_led, DBG ? 8'h01 : 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    spawn_ready = 1'b1;
    send_packet(8'h50, 8'h00, 8'h02, 8'h00, 8'h00);
    repeat (3) begin
      go_left = 1'b1; step();
      go_left = 1'b0; step();
    end
    i_y_pos0 = 8'h64; i_y_pos1 = 8'h00; i_y_vel = 8'h7F; i_gravity = 8'h03; i_is_collusion = 8'h01;
    tick();
    checks++;
    if (spawn_valid !== 1'b1 || spawn_y !== 10'd80 || spawn_vy !== 8'h02) begin
      failures++; $display("FAIL b2b_first: valid=%0b y=%0d vy=%0h expected 1 80 02", spawn_valid, spawn_y, spawn_vy);
    end
    step();
    checks++;
    if (responsing_i2c !== 1'b0) begin
      failures++; $display("FAIL b2b_done: resp=%0b expected 0", responsing_i2c);
    end
    step();
    checks++;
    if (responsing_i2c !== 1'b1) begin
      failures++; $display("FAIL b2b_pending_capture: resp=%0b expected 1", responsing_i2c);
    end
    step();
    step();
    tick();
    checks++;
    if (spawn_valid !== 1'b1 || spawn_y !== 10'd100 || spawn_vy !== 8'h7F ||
        spawn_gravity !== 2'd3 || spawn_collision !== 1'b1) begin
      failures++; $display("FAIL b2b_second: valid=%0b y=%0d vy=%0h g=%0d c=%0b expected 1 100 7f 3 1",
                           spawn_valid, spawn_y, spawn_vy, spawn_gravity, spawn_collision);
    end
    step();
    step();
    step();
    checks++;
    if (responsing_i2c !== 1'b0 || spawn_valid !== 1'b0 || dbg_led !== (DBG ? 8'h21 : 8'h00)) begin
      failures++; $display("FAIL b2b_final: resp=%0b valid=%0b dbg=%0h expected 0 0 %0h",
                           responsing_i2c, spawn_valid, dbg_led, DBG ? 8'h21 : 8'h00);
    end
  endtask

  task automatic test_reset_mid_spawn();
    spawn_ready = 1'b0;
    send_packet(8'h33, 8'h02, 8'h44, 8'h01, 8'h01);
    tick();
    checks++;
    if (spawn_valid !== 1'b1) begin
      failures++; $display("FAIL rst_pre_valid: valid=%0b expected 1", spawn_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({spawn_valid, spawn_y, spawn_vy, spawn_gravity, spawn_collision, y_clamped, responsing_i2c, dbg_led} !== '0) begin
      failures++;
      $display("FAIL rst_async_clear: valid=%0b y=%0d vy=%0h g=%0d c=%0b clamp=%0b resp=%0b dbg=%0h expected all 0",
               spawn_valid, spawn_y, spawn_vy, spawn_gravity, spawn_collision, y_clamped, responsing_i2c, dbg_led);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (spawn_valid !== 1'b0 || responsing_i2c !== 1'b0) begin
      failures++; $display("FAIL rst_idle: valid=%0b resp=%0b expected 0 0", spawn_valid, responsing_i2c);
    end
    spawn_ready = 1'b1;
    send_packet(8'h0A, 8'h00, 8'h01, 8'h00, 8'h00);
    tick();
    checks++;
    if (spawn_valid !== 1'b1 || spawn_y !== 10'd10) begin
      failures++; $display("FAIL rst_recover: valid=%0b y=%0d expected 1 10", spawn_valid, spawn_y);
    end
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_busy();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_reset_mid_spawn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_ball_rx_loader.md
Name: i2c_ball_rx_loader

Overview:
- Sits directly downstream of the I2C interface's slave side.
- Consumes the five received slave registers (y low, y high, vy, gravity, collision) and the go_left frame-complete signal.
- Snapshots and validates the packet, then hands a single ball-spawn request to local game logic, aligned to the start of a video frame.
- Drives responsing_i2c back to the interface while a received ball is still being processed.

Parameters:
- Y_MAX, 470, largest legal ball top y (480 − ball size); larger received values are clamped.
- TIMEOUT_CYC, 1_000_000, cycles spawn_valid may wait for spawn_ready before the request is dropped.
- CNT_W, 4, width of the saturating overrun and drop counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_y_pos0  in  8  received y[7:0]
- i_y_pos1  in  8  received y[9:8] in bits [1:0]; bits [7:2] ignored
- i_y_vel  in  8  received vy, two's complement
- i_gravity  in  8  received gravity counter in bits [1:0]
- i_is_collusion  in  8  received collision flag in bit [0]
- go_left  in  1  slave packet complete; level, edge-detected internally
- frame_tick  in  1  one-cycle pulse at start of frame
- ball_busy  in  1  local ball already in play
- spawn_ready  in  1  game logic accepts spawn
- spawn_valid  out  1  spawn request
- spawn_y  out  10  validated y
- spawn_vy  out  8  vy passthrough
- spawn_gravity  out  2  gravity
- spawn_collision  out  1  collision flag
- y_clamped  out  1  last accepted packet had y > Y_MAX
- responsing_i2c  out  1  busy indication to the I2C interface
- dbg_led  out  8  debug counters (optional feature)

Behaviour:
- Reset (reset low, asynchronous): FSM returns to IDLE; all outputs, the snapshot, the pending flag and the counters clear to 0.
- Edge detect: go_left is registered once. go_rise = go_left & ~go_left_q.
- FSM states and transitions:
  - IDLE: on go_rise → CAPTURE. responsing_i2c = 0.
  - CAPTURE: one cycle; snapshot all five registers into shadow regs → CHECK. responsing_i2c goes 1 here.
  - CHECK: one cycle.
    - y_raw = {i_y_pos1[1:0], i_y_pos0}.
    - If y_raw > Y_MAX: spawn_y = Y_MAX and y_clamped = 1; else spawn_y = y_raw and y_clamped = 0.
    - spawn_gravity = gravity[1:0]; spawn_collision = collision[0]; spawn_vy = vy, unchanged.
    - → WAIT_FRAME.
  - WAIT_FRAME: → SPAWN on the first frame_tick with ball_busy = 0. A frame_tick while ball_busy = 1 is ignored; keep waiting.
  - SPAWN: spawn_valid = 1 and spawn_* held stable.
    - If spawn_ready is sampled 1: spawn_valid drops the next cycle → DONE.
    - If the timeout counter reaches TIMEOUT_CYC − 1 first: drop the request, drop_cnt++ (saturating) → DONE.
    - If spawn_ready and timeout coincide in the same cycle, the accept wins; no drop is counted.
  - DONE: one cycle; responsing_i2c = 0. If pending = 1: clear pending → CAPTURE; else → IDLE.
- Latency: go_rise to spawn_valid is at least 3 cycles, plus the frame_tick wait. spawn_ready can be sampled from the first spawn_valid cycle.
- Overrun handling:
  - A go_rise in any state other than IDLE sets pending.
  - A go_rise while pending is already set increments overrun_cnt (saturating); the packet is lost.
  - The pending packet is re-snapshotted from the live registers when it is serviced.
- responsing_i2c is 1 in CAPTURE, CHECK, WAIT_FRAME and SPAWN; 0 otherwise.
- Reset asserted mid-SPAWN drops the request immediately; spawn_valid = 0 asynchronously.
- The timeout counter clears on entry to SPAWN and is CNT-sized to hold TIMEOUT_CYC.

Optional Feature:
- Macro: BALL_RX_DEBUG_CNT_EN.
- Defined: overrun_cnt and drop_cnt are implemented; dbg_led = {overrun_cnt[3:0], drop_cnt[3:0]}, zero-extended if CNT_W < 4.
- Undefined: counters are not synthesized; dbg_led tied to 0; pending and drop behaviour are otherwise identical.

Decomposition:
- Package ball_rx_pkg:
  - state enum (IDLE, CAPTURE, CHECK, WAIT_FRAME, SPAWN, DONE).
  - constants: Y_MAX default, SCREEN_H = 480, BALL_SIZE = 10.
  - typedef ball_pkt_t {y 10, vy 8, gravity 2, collision 1}.
- One sub-module is natural: ball_rx_validate, the combinational y assembly/clamp plus field extraction producing ball_pkt_t and the clamped flag.

Test Plan:
- y0 = 0x2C, y1 = 0x01, vy = 0xF6, grav = 2, coll = 1; go_left rises; frame_tick 20 cycles later; ready held high → spawn_y = 300, spawn_vy = −10, gravity = 2, collision = 1; exactly one accepted cycle; responsing_i2c returns to 0.
- y1 = 0x03, y0 = 0xFF (1023) → spawn_y = 470, y_clamped = 1.
- ball_busy = 1 across 2 frame_ticks, then 0 before the 3rd → spawn_valid asserts only after the 3rd tick.
- TIMEOUT_CYC = 16, spawn_ready held 0 → spawn_valid deasserts after 16 cycles; drop_cnt = 1; FSM back in IDLE.
- Three go_left rises during WAIT_FRAME → one pending spawn is serviced after the first; overrun_cnt = 2 with BALL_RX_DEBUG_CNT_EN.
- Assert reset during SPAWN → spawn_valid = 0 at once; all outputs 0; FSM in IDLE after release.
